snes_gamepad_reader: RTL and testbench
======================================

# snes_gamepad_reader

Serial reader for the SNES-style gamepad that produces the 12-bit `gamepad_input` bus consumed by `Top`. Once per video frame, on the rising edge of `v_sync`, it drives the pad's latch/clock lines, shifts in 16 active-low button bits and publishes a registered, active-high 12-bit button vector. It also outputs one-cycle "newly pressed" pulses, so the map/cursor logic can use edges instead of levels.

## Interface
- `LATCH_CYCLES`, 600: width of the `pad_latch` pulse in clock cycles (12 µs at 50 MHz); must be ≥ 2.
- `HALF_CYCLES`, 300: length of each `pad_clk` phase in clock cycles (6 µs at 50 MHz); must be ≥ 4 to absorb the synchronizer delay.
- `clock`  in  1  system clock. This is the only clock; every flop is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `v_sync`  in  1  frame strobe, synchronous to `clock`. Its rising edge starts a read.
- `pad_data`  in  1  serial data from the pad, asynchronous, active-low (0 = pressed).
- `pad_latch`  out  1  latch pulse to the pad, active-high.
- `pad_clk`  out  1  shift clock to the pad; idles high.
- `gamepad_input`  out  12  button state, active-high (1 = pressed).
- `gamepad_pressed`  out  12  one-cycle pulse per bit that went 0→1 in this update.
- `frame_valid`  out  1  one-cycle pulse when `gamepad_input` has just been updated.
- `busy`  out  1  high while a read is in progress (any state other than IDLE).

## Operation
- Bit map, in serial order (bit i = i-th sampled bit): 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R. Bits 12–15 are sampled and then discarded.
- `pad_data` passes through a 2-FF synchronizer (reset value 1) before use.
- `v_sync` is registered into `v_sync_q` (reset value 1). Start condition: `v_sync & ~v_sync_q` while in IDLE.
- FSM states: IDLE → LATCH → SETTLE → CLK_LOW ⇄ CLK_HIGH → DONE → IDLE.
  - IDLE: `pad_latch`=0, `pad_clk`=1. Leave on the start condition.
  - LATCH: `pad_latch`=1 for exactly `LATCH_CYCLES` cycles.
  - SETTLE: `pad_latch`=0, `pad_clk`=1 for `HALF_CYCLES` cycles. On the last cycle, sample bit 0.
  - CLK_LOW: `pad_clk`=0 for `HALF_CYCLES` cycles.
  - CLK_HIGH: `pad_clk`=1 for `HALF_CYCLES` cycles. On the last cycle, sample bit n (n = 1..15) and increment the 4-bit bit counter.
  - After bit 15 is sampled, go to DONE. There are exactly 15 `pad_clk` falling edges per read.
  - DONE: one cycle. `gamepad_input` ← ~shift[11:0]; `gamepad_pressed` ← new & ~old; `frame_valid`=1. All three are registered, so they are visible in the cycle after DONE.
- `gamepad_pressed` and `frame_valid` are 0 in every cycle except the one following DONE.
- `gamepad_input` holds its value between updates. It is never partially updated.
- Phase counter: ⌈log2(max(LATCH_CYCLES, HALF_CYCLES))⌉ bits, cleared on every state change.

## Timing
- Reset values (`reset`=0 at a clock edge): state IDLE, `pad_latch`=0, `pad_clk`=1, `gamepad_input`=0, `gamepad_pressed`=0, `frame_valid`=0, `busy`=0, shift register all 1s, counters 0.
- Let edge E0 be the edge that detects the start condition.
  - `pad_latch` is high for edges E0+1 … E0+LATCH_CYCLES.
  - Bit 15 is sampled at edge E0+LATCH_CYCLES+31·HALF_CYCLES.
  - Outputs update at that edge +1. `frame_valid` is high for the following cycle.
- Defaults: update 9901 cycles after E0, which is well under a 60 Hz frame.
- A `v_sync` rising edge while `busy`=1 is ignored, not queued.
- `v_sync` held high through reset does not cause a read when reset is released, because `v_sync_q` resets to 1.
- Reset asserted mid-read aborts immediately. All outputs go to their reset values and no partial vector is published. The next read needs a fresh `v_sync` rising edge.
- A `pad_data` change reaches the sampling point within 2 cycles. Sampling happens `HALF_CYCLES` (≥4) cycles after the pad shifts on the `pad_clk` rising edge.

## Test plan
Use a bench pad model that shifts on `pad_clk` rising edges and reloads on `pad_latch`. Set LATCH_CYCLES=4 and HALF_CYCLES=4.
- Reset hold, then release with `v_sync`=1 → all outputs at reset values, `pad_clk`=1, no latch pulse for 200 cycles.
- Pad presses Start and L (serial bits 3 and 10 low), `v_sync` rising edge → `pad_latch` high for 4 cycles, 15 `pad_clk` falling edges, then `gamepad_input`=12'h408, `gamepad_pressed`=12'h408 and `frame_valid`=1 for one cycle, 129 cycles after E0.
- Second frame with the same buttons, then a third frame with only Up (bit 4) → second frame: `gamepad_input`=12'h408, `gamepad_pressed`=0. Third frame: `gamepad_input`=12'h010, `gamepad_pressed`=12'h010.
- Extra `v_sync` rising edge at E0+50 → exactly one latch pulse and one `frame_valid` for that frame.
- Reset pulsed at E0+60 during a read with A pressed → outputs return to reset values at once and `gamepad_input` stays 0. The next `v_sync` rising edge gives `gamepad_input`=12'h100 after a full 129-cycle read.
- `pad_data` held high (no pad), then bits 12–15 driven low with no buttons pressed → `gamepad_input`=0 in both cases and `gamepad_pressed` never pulses.

Source files
------------

// File: rtl/snes_gamepad_reader_if.sv
// Signal bundle between the SNES gamepad reader, the pad connector and the frame logic.
// The master side is the reader; the slave side is the pad plus frame strobe source/consumer.
interface snes_gamepad_reader_if;
  logic        v_sync;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [11:0] gamepad_input;
  logic [11:0] gamepad_pressed;
  logic        frame_valid;
  logic        busy;

  modport master (
    input  v_sync,
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output gamepad_input,
    output gamepad_pressed,
    output frame_valid,
    output busy
  );

  modport slave (
    output v_sync,
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  gamepad_input,
    input  gamepad_pressed,
    input  frame_valid,
    input  busy
  );
endinterface

// File: rtl/snes_gamepad_reader.sv
// Once-per-frame serial reader for an SNES-style pad: latch, 16 shifted active-low bits,
// registered active-high 12-bit button vector plus one-cycle newly-pressed pulses.
module snes_gamepad_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic                  clock,
  input  logic                  reset,
  snes_gamepad_reader_if.master bus
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_SETTLE   = 3'd2,
    S_CLK_LOW  = 3'd3,
    S_CLK_HIGH = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             v_sync_q, v_sync_d;
  logic             pad_meta_q, pad_meta_d;
  logic             pad_sync_q, pad_sync_d;
  logic             pad_latch_q, pad_latch_d;
  logic             pad_clk_q, pad_clk_d;
  logic             busy_q, busy_d;
  logic [11:0]      gamepad_input_q, gamepad_input_d;
  logic [11:0]      gamepad_pressed_q, gamepad_pressed_d;
  logic             frame_valid_q, frame_valid_d;
  logic             start_s;

  assign start_s = bus.v_sync & ~v_sync_q;

  // Next-state, datapath and registered-output lookahead (pad lines derived from state_d).
  always_comb begin
    state_d           = state_q;
    phase_d           = phase_q + PHASE_ONE;
    bit_cnt_d         = bit_cnt_q;
    shift_d           = shift_q;
    v_sync_d          = bus.v_sync;
    pad_meta_d        = bus.pad_data;
    pad_sync_d        = pad_meta_q;
    gamepad_input_d   = gamepad_input_q;
    gamepad_pressed_d = 12'h000;
    frame_valid_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 4'd0;
        if (start_s) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_LATCH;
        end
      end
      S_SETTLE: begin
        if (phase_q == HALF_LAST) begin
          shift_d = {pad_sync_q, shift_q[15:1]};
          state_d = S_CLK_LOW;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_CLK_LOW: begin
        if (phase_q == HALF_LAST) begin
          state_d = S_CLK_HIGH;
        end else begin
          state_d = S_CLK_LOW;
        end
      end
      S_CLK_HIGH: begin
        if (phase_q == HALF_LAST) begin
          shift_d   = {pad_sync_q, shift_q[15:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // bit_cnt_q == 14 means the bit being sampled now is bit 15
          if (bit_cnt_q == 4'd14) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLK_LOW;
          end
        end else begin
          state_d = S_CLK_HIGH;
        end
      end
      S_DONE: begin
        gamepad_input_d   = ~shift_q[11:0];
        gamepad_pressed_d = ~shift_q[11:0] & ~gamepad_input_q;
        frame_valid_d     = 1'b1;
        state_d           = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_d;
    end

    pad_latch_d = (state_d == S_LATCH);
    pad_clk_d   = (state_d != S_CLK_LOW);
    busy_d      = (state_d != S_IDLE);
  end

  // State, counters, synchronizers and registered outputs; reset aborts any read in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      phase_q           <= '0;
      bit_cnt_q         <= 4'd0;
      shift_q           <= 16'hFFFF;
      v_sync_q          <= 1'b1;
      pad_meta_q        <= 1'b1;
      pad_sync_q        <= 1'b1;
      pad_latch_q       <= 1'b0;
      pad_clk_q         <= 1'b1;
      busy_q            <= 1'b0;
      gamepad_input_q   <= 12'h000;
      gamepad_pressed_q <= 12'h000;
      frame_valid_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      phase_q           <= phase_d;
      bit_cnt_q         <= bit_cnt_d;
      shift_q           <= shift_d;
      v_sync_q          <= v_sync_d;
      pad_meta_q        <= pad_meta_d;
      pad_sync_q        <= pad_sync_d;
      pad_latch_q       <= pad_latch_d;
      pad_clk_q         <= pad_clk_d;
      busy_q            <= busy_d;
      gamepad_input_q   <= gamepad_input_d;
      gamepad_pressed_q <= gamepad_pressed_d;
      frame_valid_q     <= frame_valid_d;
    end
  end

  assign bus.pad_latch       = pad_latch_q;
  assign bus.pad_clk         = pad_clk_q;
  assign bus.busy            = busy_q;
  assign bus.gamepad_input   = gamepad_input_q;
  assign bus.gamepad_pressed = gamepad_pressed_q;
  assign bus.frame_valid     = frame_valid_q;

endmodule

// File: tb/tb_snes_gamepad_reader.sv
// Directed bench for snes_gamepad_reader with a shift-register pad model (LATCH=4, HALF=4).
module tb_snes_gamepad_reader;

  logic clock = 1'b0;
  logic reset = 1'b0;

  snes_gamepad_reader_if bus ();

  snes_gamepad_reader #(
    .LATCH_CYCLES (4),
    .HALF_CYCLES  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Pad model: reload on latch, shift one bit on each pad_clk rising edge.
  logic [15:0] pad_btn  = 16'hFFFF;
  logic [15:0] pad_sr   = 16'hFFFF;
  logic        pad_prev = 1'b1;
  always @(posedge clock) begin
    pad_prev <= bus.pad_clk;
    if (bus.pad_latch) begin
      pad_sr <= pad_btn;
    end else if (bus.pad_clk && !pad_prev) begin
      pad_sr <= {1'b1, pad_sr[15:1]};
    end
  end
  assign bus.pad_data = pad_sr[0];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   latch_cnt = 0;
  int   fall_cnt  = 0;
  int   fv_cnt    = 0;
  int   press_cnt = 0;
  logic mon_prev  = 1'b1;
  always @(negedge clock) begin
    mon_prev <= bus.pad_clk;
    if (bus.pad_latch) latch_cnt <= latch_cnt + 1;
    if (mon_prev && !bus.pad_clk) fall_cnt <= fall_cnt + 1;
    if (bus.frame_valid) fv_cnt <= fv_cnt + 1;
    if (bus.gamepad_pressed != 12'h000) press_cnt <= press_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int e0     = 0;
  int b_latch, b_fall, b_fv, b_press;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic snap();
    b_latch = latch_cnt;
    b_fall  = fall_cnt;
    b_fv    = fv_cnt;
    b_press = press_cnt;
  endtask

  task automatic vsync_rise();
    bus.v_sync = 1'b0;
    tick(2);
    bus.v_sync = 1'b1;
    tick(1);
    e0 = cyc;
  endtask

  task automatic wait_fv(input string tag, input logic [11:0] exp_in, input logic [11:0] exp_pr);
    int   n;
    logic got;
    n = 0;
    while (!bus.frame_valid && n < 400) begin
      tick(1);
      n++;
    end
    got = bus.frame_valid;
    check({tag, "_fv_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, cyc - e0, 32'd129);
    check({tag, "_input"}, {20'd0, bus.gamepad_input}, {20'd0, exp_in});
    check({tag, "_pressed"}, {20'd0, bus.gamepad_pressed}, {20'd0, exp_pr});
    tick(1);
    check({tag, "_fv_one_cycle"}, {31'd0, bus.frame_valid}, 32'd0);
    check({tag, "_pressed_cleared"}, {20'd0, bus.gamepad_pressed}, 32'd0);
    check({tag, "_input_hold"}, {20'd0, bus.gamepad_input}, {20'd0, exp_in});
  endtask

  task automatic frame_counts(input string tag);
    tick(3);
    check({tag, "_latch_cycles"}, latch_cnt - b_latch, 32'd4);
    check({tag, "_clk_falls"}, fall_cnt - b_fall, 32'd15);
    check({tag, "_fv_count"}, fv_cnt - b_fv, 32'd1);
  endtask

  initial begin
    // Reset with v_sync held high, then release: no read may start.
    bus.v_sync = 1'b1;
    reset      = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    snap();
    check("rst_latch", {31'd0, bus.pad_latch}, 32'd0);
    check("rst_pad_clk", {31'd0, bus.pad_clk}, 32'd1);
    check("rst_input", {20'd0, bus.gamepad_input}, 32'd0);
    check("rst_pressed", {20'd0, bus.gamepad_pressed}, 32'd0);
    check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    tick(200);
    check("idle_no_latch", latch_cnt - b_latch, 32'd0);
    check("idle_no_fv", fv_cnt - b_fv, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Frame 1: Start + L.
    pad_btn = ~16'h0408;
    snap();
    vsync_rise();
    check("f1_busy", {31'd0, bus.busy}, 32'd1);
    check("f1_latch_on", {31'd0, bus.pad_latch}, 32'd1);
    wait_fv("f1", 12'h408, 12'h408);
    frame_counts("f1");

    // Frame 2: same buttons, nothing newly pressed.
    snap();
    vsync_rise();
    wait_fv("f2", 12'h408, 12'h000);
    frame_counts("f2");

    // Frame 3: only Up; extra v_sync rising edge at E0+50 must be ignored.
    pad_btn = ~16'h0010;
    snap();
    vsync_rise();
    tick(10);
    bus.v_sync = 1'b0;
    tick(39);
    bus.v_sync = 1'b1;
    wait_fv("f3", 12'h010, 12'h010);
    frame_counts("f3");
    tick(150);
    check("f3_extra_fv", fv_cnt - b_fv, 32'd1);
    check("f3_extra_latch", latch_cnt - b_latch, 32'd4);

    // Reset at E0+60 during a read with A pressed.
    pad_btn = ~16'h0100;
    vsync_rise();
    tick(59);
    reset = 1'b0;
    tick(1);
    check("abort_input", {20'd0, bus.gamepad_input}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_latch", {31'd0, bus.pad_latch}, 32'd0);
    check("abort_pad_clk", {31'd0, bus.pad_clk}, 32'd1);
    check("abort_fv", {31'd0, bus.frame_valid}, 32'd0);
    tick(2);
    reset = 1'b1;
    snap();
    tick(150);
    check("abort_no_fv", fv_cnt - b_fv, 32'd0);
    check("abort_input_held", {20'd0, bus.gamepad_input}, 32'd0);
    snap();
    vsync_rise();
    wait_fv("f4", 12'h100, 12'h100);
    frame_counts("f4");

    // No pad: data line stays high.
    pad_btn = 16'hFFFF;
    snap();
    vsync_rise();
    wait_fv("nopad", 12'h000, 12'h000);
    frame_counts("nopad");
    check("nopad_press_pulses", press_cnt - b_press, 32'd0);

    // Only the discarded bits 12-15 driven low.
    pad_btn = 16'h0FFF;
    snap();
    vsync_rise();
    wait_fv("hibits", 12'h000, 12'h000);
    frame_counts("hibits");
    check("hibits_press_pulses", press_cnt - b_press, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
